// File: rtl/regfile_rob_multiport_pkg.sv
// Shared types for the architectural register file with ROB rename status.
// Register 0 and indices beyond NUM_REGS are never stored, renamed or read back.
package rob_pkg;

  localparam int ROB_Entry_WIDTH = 5;
  localparam int DATA_WIDTH      = 32;
  localparam int NUM_REGS        = 32;
  localparam int REG_IDX_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef logic [ROB_Entry_WIDTH-1:0] rob_tag_t;
  typedef logic [REG_IDX_W-1:0]       reg_idx_t;
  typedef logic [DATA_WIDTH-1:0]      data_t;

  typedef struct packed {
    logic     busy;
    rob_tag_t tag;
  } reg_status_t;

  // True for registers that hold state: non-zero and inside the file.
  function automatic logic reg_live(input reg_idx_t idx);
    return (idx != '0) && ({1'b0, idx} < (REG_IDX_W+1)'(NUM_REGS));
  endfunction

endpackage

// File: rtl/regfile_rob_multiport_if.sv
// Commit, rename, flush and read-port bundle between the core and the register file.
// The master side is the core; the slave side is the register file.
interface regfile_rob_multiport_if
  import rob_pkg::*;
#(
  parameter int NUM_COMMIT = 2,
  parameter int NUM_RD     = 4
) ();

  logic     [NUM_COMMIT-1:0] CM_Wen;
  rob_tag_t [NUM_COMMIT-1:0] CM_ROBEN;
  reg_idx_t [NUM_COMMIT-1:0] CM_DRindex;
  data_t    [NUM_COMMIT-1:0] CM_Data;

  logic     IQ_Wen;
  reg_idx_t IQ_DRindex;
  rob_tag_t IQ_ROBEN;

  logic     Flush;

  reg_idx_t [NUM_RD-1:0] RP_index;
  data_t    [NUM_RD-1:0] RP_Data;
  logic     [NUM_RD-1:0] RP_Busy;
  rob_tag_t [NUM_RD-1:0] RP_ROBEN;

  modport master (
    output CM_Wen, CM_ROBEN, CM_DRindex, CM_Data,
    output IQ_Wen, IQ_DRindex, IQ_ROBEN, Flush, RP_index,
    input  RP_Data, RP_Busy, RP_ROBEN
  );

  modport slave (
    input  CM_Wen, CM_ROBEN, CM_DRindex, CM_Data,
    input  IQ_Wen, IQ_DRindex, IQ_ROBEN, Flush, RP_index,
    output RP_Data, RP_Busy, RP_ROBEN
  );

endinterface

// File: rtl/regfile_rob_multiport_read_port.sv
// One combinational read port with same-cycle commit bypass.
// Same-cycle renames are deliberately not visible: the reader is older.
module regfile_read_port
  import rob_pkg::*;
#(
  parameter int NUM_COMMIT = 2
) (
  input  reg_idx_t                  idx,
  input  data_t       [NUM_REGS-1:0] rf_val,
  input  reg_status_t [NUM_REGS-1:0] rf_st,
  input  logic     [NUM_COMMIT-1:0] cm_wen,
  input  rob_tag_t [NUM_COMMIT-1:0] cm_roben,
  input  reg_idx_t [NUM_COMMIT-1:0] cm_idx,
  input  data_t    [NUM_COMMIT-1:0] cm_data,
  output data_t                     rd_data,
  output logic                      rd_busy,
  output rob_tag_t                  rd_tag
);

  reg_status_t cur;
  logic        clr;

  always_comb begin
    rd_data = '0;
    rd_busy = 1'b0;
    rd_tag  = '0;
    cur     = '0;
    clr     = 1'b0;
    if (reg_live(idx)) begin
      cur     = rf_st[idx];
      rd_data = rf_val[idx];
      // Ascending scan so the youngest (highest) commit port supplies the data.
      for (int p = 0; p < NUM_COMMIT; p++) begin
        if (cm_wen[p] && cm_idx[p] == idx) begin
          rd_data = cm_data[p];
          if (cur.busy && cm_roben[p] == cur.tag) clr = 1'b1;
        end
      end
      rd_busy = cur.busy && !clr;
      rd_tag  = clr ? '0 : cur.tag;
    end
  end

endmodule

// File: rtl/regfile_rob_multiport.sv
// Architectural register file holding committed values plus busy/tag rename status.
// In-order commit writes, one rename per cycle, flush, and NUM_RD bypassed read ports.
module regfile_rob_multiport
  import rob_pkg::*;
#(
  parameter int NUM_COMMIT = 2,
  parameter int NUM_RD     = 4
) (
  input logic                  clk,
  input logic                  rst,
  regfile_rob_multiport_if.slave bus
);

  data_t       [NUM_REGS-1:0] val, val_nxt;
  reg_status_t [NUM_REGS-1:0] st,  st_nxt;

  always_comb begin
    val_nxt = val;
    st_nxt  = st;
    // Commit data is unconditional; a tag mismatch means a younger rename is pending.
    for (int p = 0; p < NUM_COMMIT; p++) begin
      if (bus.CM_Wen[p] && reg_live(bus.CM_DRindex[p])) begin
        val_nxt[bus.CM_DRindex[p]] = bus.CM_Data[p];
        if (st[bus.CM_DRindex[p]].busy &&
            st[bus.CM_DRindex[p]].tag == bus.CM_ROBEN[p])
          st_nxt[bus.CM_DRindex[p]] = '0;
      end
    end
    // Flush wipes all rename state and swallows the same-cycle rename.
    if (bus.Flush) begin
      st_nxt = '0;
    end else if (bus.IQ_Wen && reg_live(bus.IQ_DRindex)) begin
      st_nxt[bus.IQ_DRindex] = '{busy: 1'b1, tag: bus.IQ_ROBEN};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      val <= '0;
      st  <= '0;
    end else begin
      val <= val_nxt;
      st  <= st_nxt;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    regfile_read_port #(
      .NUM_COMMIT (NUM_COMMIT)
    ) u_rd (
      .idx      (bus.RP_index[g]),
      .rf_val   (val),
      .rf_st    (st),
      .cm_wen   (bus.CM_Wen),
      .cm_roben (bus.CM_ROBEN),
      .cm_idx   (bus.CM_DRindex),
      .cm_data  (bus.CM_Data),
      .rd_data  (bus.RP_Data[g]),
      .rd_busy  (bus.RP_Busy[g]),
      .rd_tag   (bus.RP_ROBEN[g])
    );
  end

endmodule

// File: doc/regfile_rob_multiport.md
Name: regfile_rob_multiport

Overview:
- Next-generation architectural register file with ROB rename status for the out-of-order core.
- Holds committed register values plus a per-register busy bit and producing-ROB tag.
- Accepts NUM_COMMIT in-order commit writes and one issue-stage rename per cycle; serves NUM_RD combinational read ports with commit bypass.
- Sits between the issue queue, the ROB commit stage and the operand-read logic of the reservation stations.

Parameters:
- ROB_Entry_WIDTH, 5, ROB tag width.
- DATA_WIDTH, 32, register data width.
- NUM_REGS, 32, number of registers; REG_IDX_W = clog2(NUM_REGS) is a derived localparam.
- NUM_COMMIT, 2, commit write ports; higher index is younger in program order.
- NUM_RD, 4, read ports.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- CM_Wen  in  NUM_COMMIT  commit write enables.
- CM_ROBEN  in  NUM_COMMIT*ROB_Entry_WIDTH  committing ROB tags, packed.
- CM_DRindex  in  NUM_COMMIT*REG_IDX_W  commit destination indices.
- CM_Data  in  NUM_COMMIT*DATA_WIDTH  commit data.
- IQ_Wen  in  1  rename enable from the issue stage.
- IQ_DRindex  in  REG_IDX_W  destination being renamed.
- IQ_ROBEN  in  ROB_Entry_WIDTH  newly allocated ROB tag.
- Flush  in  1  mispredict/exception flush of rename state.
- RP_index  in  NUM_RD*REG_IDX_W  read indices.
- RP_Data  out  NUM_RD*DATA_WIDTH  read values.
- RP_Busy  out  NUM_RD  register awaits an in-flight producer.
- RP_ROBEN  out  NUM_RD*ROB_Entry_WIDTH  producer tag; 0 when not busy.

Behaviour:
- State per register: value[DATA_WIDTH], busy, tag[ROB_Entry_WIDTH].
- Reset (rst=0, asynchronous): all values, busy bits and tags cleared. Reset takes effect immediately mid-operation; no write in flight survives.
- Register 0: reads 0, is never busy, and ignores all writes and renames.
- Commit, at the rising edge, per port with CM_Wen=1:
  - value[rd] <= CM_Data unconditionally, since commit is in order.
  - busy[rd] is cleared only if busy=1 and tag[rd]==CM_ROBEN; on a mismatch a younger rename is pending, so busy and tag are kept.
- Several commit ports to the same rd in one cycle: the highest port index wins the data. Busy is cleared if any matching port's tag equals the current tag.
- Rename: IQ_Wen=1 sets busy[IQ_DRindex] and tag <= IQ_ROBEN at the edge.
  - Rename and commit to the same register in the same cycle: commit data is written, and the rename's busy/tag overrides any clear.
- Flush=1: all busy bits and tags clear at the edge. Commit data writes in the same cycle still apply. IQ_Wen in the same cycle is ignored.
- Reads are combinational, zero latency, with commit bypass:
  - If any enabled commit port targets RP_index this cycle, RP_Data returns the youngest such CM_Data. RP_Busy and RP_ROBEN reflect the post-commit state, i.e. cleared if the tag matches.
  - Reads do NOT bypass the same-cycle rename; the reader is older than the renaming instruction.
- No internal FIFO; no handshake. Every enabled request is accepted every cycle.
- Out-of-range index (>= NUM_REGS when NUM_REGS is not a power of two): reads return 0/not busy; writes are dropped.

Decomposition:
- Shared package rob_pkg: ROB_Entry_WIDTH, DATA_WIDTH, NUM_REGS, REG_IDX_W and a reg_status typedef {busy, tag}.
- One sub-module, regfile_read_port: a single read port with commit bypass, instantiated NUM_RD times by generate.
- Status and value arrays and the write/priority logic stay in the top module.

Test Plan:
- Reset, then read r0..r9 → RP_Data=0, RP_Busy=0, RP_ROBEN=0 on all ports; assert rst low mid-run → state clears immediately, before the next edge.
- Rename r1 to tag 2; next cycle commit r1, data 123, tag 2 → after the edge r1 = 123, busy=0. During the commit cycle the read bypass shows 123 with busy=0.
- Rename r3 to tag 4, then r3 to tag 7; commit r3 with tag 4, data 55 → value 55, busy=1, RP_ROBEN=7. Commit tag 7, data 66 → value 66, busy=0.
- Same cycle: commit r5 with tag 1 (busy with tag 1) and rename r5 to tag 9 → value updated, busy=1, tag 9.
- Two commit ports to r6 (port0 data 10, port1 data 20) → r6 = 20, and the bypass read shows 20.
- Rename r2, r4, r8; assert Flush with a simultaneous rename of r9 and a commit of r2 with data 77 → all busy=0, r9 not busy, r2 = 77. A write to r0 leaves r0 reading 0.
